// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and helpers for the UART TX arbiter.
// Imported by rr_pointer_arbiter and uart_tx_arbiter.
package uart_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_START,
      S_WAIT_DONE,
      S_GAP
   } arb_state_t;

   localparam logic [2:0] TX_IDLE_DEFAULT = 3'd0;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_pointer_arbiter.sv
// rr_pointer_arbiter: last-grant pointer plus combinational round-robin pick.
// Reusable for any peripheral shared between a few requesters.
module rr_pointer_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = clog2(N)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic [N-1:0]  req,
   input  logic          update,
   output logic          pick_valid,
   output logic [IW-1:0] pick_id
);

   logic [IW-1:0] ptr;
   int            base;
   int            idx;

   // Scan from farthest to nearest so the nearest set bit after ptr wins.
   always_comb begin
      base       = (int'(ptr) >= N) ? N - 1 : int'(ptr);
      idx        = 0;
      pick_id    = '0;
      pick_valid = |req;
      for (int k = N; k >= 1; k--) begin
         idx = (base + k) % N;
         if (req[idx]) pick_id = IW'(idx);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ptr <= IW'(N - 1);
      end else if (update) begin
         ptr <= pick_id;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART_Tx between NUM_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to add the WAIT_START watchdog and timeout_err.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int         NUM_REQ        = 2,
   parameter logic [2:0] IDLE_STATE     = TX_IDLE_DEFAULT,
   parameter int         GAP_CYCLES     = 0,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [7:0]                 tx_data,
   output logic                       tx_send,
   input  logic [2:0]                 tx_state,
   output logic [clog2(NUM_REQ)-1:0]  grant_id,
   output logic                       busy
`ifdef UART_ARB_TIMEOUT_EN
   ,
   output logic                       timeout_err
`endif
);

   localparam int IW = clog2(NUM_REQ);
   localparam int GW = (GAP_CYCLES < 2) ? 1 : clog2(GAP_CYCLES);

   arb_state_t    state;
   arb_state_t    state_d;
   logic [GW-1:0] gap_cnt;
   logic [GW-1:0] gap_d;
   logic          pick_valid;
   logic [IW-1:0] pick_id;
   logic          grant;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] wd_cnt;
   logic [TW-1:0] wd_d;
   logic          err_d;
`endif

   assign grant = (state == S_IDLE) && pick_valid;
   assign busy  = (state != S_IDLE);

   rr_pointer_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .clk        (clk),
      .n_rst      (n_rst),
      .req        (req),
      .update     (grant),
      .pick_valid (pick_valid),
      .pick_id    (pick_id)
   );

   always_comb begin
      state_d = state;
      gap_d   = gap_cnt;
`ifdef UART_ARB_TIMEOUT_EN
      wd_d    = wd_cnt;
      err_d   = timeout_err;
`endif
      unique case (state)
         S_IDLE: begin
            if (pick_valid) state_d = S_SEND;
         end
         S_SEND: begin
            state_d = S_WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
            wd_d    = '0;
`endif
         end
         S_WAIT_START: begin
`ifdef UART_ARB_TIMEOUT_EN
            if (tx_state != IDLE_STATE) begin
               state_d = S_WAIT_DONE;
            end else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_cnt + TW'(1);
            end
`else
            if (tx_state != IDLE_STATE) state_d = S_WAIT_DONE;
`endif
         end
         S_WAIT_DONE: begin
            if (tx_state == IDLE_STATE) begin
               if (GAP_CYCLES > 0) begin
                  state_d = S_GAP;
                  gap_d   = GW'(GAP_CYCLES - 1);
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == '0) state_d = S_IDLE;
            else gap_d = gap_cnt - GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= S_IDLE;
         gap_cnt <= '0;
      end else begin
         state   <= state_d;
         gap_cnt <= gap_d;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tx_send  <= 1'b0;
         ack      <= '0;
         tx_data  <= '0;
         grant_id <= '0;
      end else begin
         tx_send <= grant;
         ack     <= grant ? (NUM_REQ'(1) << pick_id) : '0;
         if (grant) begin
            tx_data  <= req_data[8*pick_id +: 8];
            grant_id <= pick_id;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         wd_cnt      <= wd_d;
         timeout_err <= err_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench with a round-robin reference model.
// Instance a: 2 requesters, no gap; instance b: 3 requesters, 5-cycle gap.
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic n_rst;

   logic [1:0]  a_req;
   logic [15:0] a_data;
   logic [1:0]  a_ack;
   logic [7:0]  a_txd;
   logic        a_send;
   logic [2:0]  a_st;
   logic [0:0]  a_gid;
   logic        a_busy;

   logic [2:0]  b_req;
   logic [23:0] b_data;
   logic [2:0]  b_ack;
   logic [7:0]  b_txd;
   logic        b_send;
   logic [2:0]  b_st;
   logic [1:0]  b_gid;
   logic        b_busy;

`ifdef UART_ARB_TIMEOUT_EN
   logic a_terr;
   logic b_terr;
`endif

   int checks = 0;
   int passed = 0;
   int a_last;
   int b_last;

   uart_tx_arbiter #(
      .NUM_REQ        (2),
      .IDLE_STATE     (3'd0),
      .GAP_CYCLES     (0),
      .TIMEOUT_CYCLES (8)
   ) u_a (
      .clk      (clk),
      .n_rst    (n_rst),
      .req      (a_req),
      .req_data (a_data),
      .ack      (a_ack),
      .tx_data  (a_txd),
      .tx_send  (a_send),
      .tx_state (a_st),
      .grant_id (a_gid),
      .busy     (a_busy)
`ifdef UART_ARB_TIMEOUT_EN
      ,
      .timeout_err (a_terr)
`endif
   );

   uart_tx_arbiter #(
      .NUM_REQ        (3),
      .IDLE_STATE     (3'd0),
      .GAP_CYCLES     (5),
      .TIMEOUT_CYCLES (64)
   ) u_b (
      .clk      (clk),
      .n_rst    (n_rst),
      .req      (b_req),
      .req_data (b_data),
      .ack      (b_ack),
      .tx_data  (b_txd),
      .tx_send  (b_send),
      .tx_state (b_st),
      .grant_id (b_gid),
      .busy     (b_busy)
`ifdef UART_ARB_TIMEOUT_EN
      ,
      .timeout_err (b_terr)
`endif
   );

   // Reference rule: first pending requester after the last grant, wrapping.
   function automatic int rr_pick(input logic [3:0] r, input int last, input int n);
      for (int k = 1; k <= n; k++)
         if (r[(last + k) % n]) return (last + k) % n;
      return -1;
   endfunction

   task automatic a_wait_send(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (a_send) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // UART model: stays idle for pre cycles, then busy for len cycles.
   task automatic a_frame(input int pre, input int len);
      repeat (pre) @(negedge clk);
      a_st = 3'd3;
      repeat (len) @(negedge clk);
      a_st = 3'd0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (a_send !== 1'b0) $display("FAIL rst_a_send got %0b exp 0", a_send); else passed++;
      checks++; if (a_ack !== 2'b00) $display("FAIL rst_a_ack got %0b exp 0", a_ack); else passed++;
      checks++; if (a_txd !== 8'h00) $display("FAIL rst_a_txd got %0h exp 0", a_txd); else passed++;
      checks++; if (a_gid !== 1'b0) $display("FAIL rst_a_gid got %0d exp 0", a_gid); else passed++;
      checks++; if (a_busy !== 1'b0) $display("FAIL rst_a_busy got %0b exp 0", a_busy); else passed++;
      checks++; if (b_busy !== 1'b0 || b_send !== 1'b0) $display("FAIL rst_b got busy=%0b send=%0b exp 0", b_busy, b_send); else passed++;
`ifdef UART_ARB_TIMEOUT_EN
      checks++; if (a_terr !== 1'b0) $display("FAIL rst_terr got %0b exp 0", a_terr); else passed++;
`endif
      n_rst  = 1'b1;
      a_last = 1;
      b_last = 2;
      @(negedge clk);
      checks++; if (a_busy !== 1'b0 || a_send !== 1'b0) $display("FAIL idle_noreq got busy=%0b send=%0b exp 0", a_busy, a_send); else passed++;
   endtask

   task automatic test_contention();
      bit         ok;
      int         exp;
      logic [1:0] prev;
      a_req  = 2'b11;
      a_data = {8'h22, 8'h11};
      prev   = 2'b00;
      for (int i = 0; i < 6; i++) begin
         a_wait_send(ok);
         exp = rr_pick({2'b00, a_req}, a_last, 2);
         checks++; if (!ok) $display("FAIL cont_send_timeout iter %0d got none exp tx_send", i); else passed++;
         checks++; if (a_gid !== 1'(exp)) $display("FAIL cont_gid iter %0d got %0d exp %0d", i, a_gid, exp); else passed++;
         checks++; if (a_txd !== a_data[8*exp +: 8]) $display("FAIL cont_txd iter %0d got %0h exp %0h", i, a_txd, a_data[8*exp +: 8]); else passed++;
         checks++; if (a_ack !== 2'(1 << exp) || a_ack === prev) $display("FAIL cont_ack iter %0d got %0b exp %0b prev %0b", i, a_ack, 2'(1 << exp), prev); else passed++;
         prev   = a_ack;
         a_last = exp;
         a_frame(0, $urandom_range(2, 5));
      end
      a_req = 2'b00;
      @(negedge clk);
      checks++; if (a_busy !== 1'b0) $display("FAIL cont_end_busy got %0b exp 0", a_busy); else passed++;
   endtask

   task automatic test_single();
      a_data[7:0] = 8'hA5;
      a_req       = 2'b01;
      @(negedge clk);
      checks++; if (a_send !== 1'b1) $display("FAIL single_send got %0b exp 1", a_send); else passed++;
      checks++; if (a_ack !== 2'b01) $display("FAIL single_ack got %0b exp 01", a_ack); else passed++;
      checks++; if (a_txd !== 8'hA5) $display("FAIL single_txd got %0h exp a5", a_txd); else passed++;
      a_req  = 2'b00;
      a_last = 0;
      repeat (3) @(negedge clk);
      checks++; if (a_busy !== 1'b1) $display("FAIL single_wait_start got %0b exp 1", a_busy); else passed++;
      a_st = 3'd3;
      repeat (4) @(negedge clk);
      checks++; if (a_busy !== 1'b1 || a_send !== 1'b0 || a_ack !== 2'b00) $display("FAIL single_wait_done got busy=%0b send=%0b ack=%0b exp 1,0,0", a_busy, a_send, a_ack); else passed++;
      checks++; if (a_txd !== 8'hA5) $display("FAIL single_hold got %0h exp a5", a_txd); else passed++;
      a_st = 3'd0;
      @(negedge clk);
      checks++; if (a_busy !== 1'b0) $display("FAIL single_done got %0b exp 0", a_busy); else passed++;
   endtask

   task automatic test_random();
      logic [1:0]  m;
      logic [15:0] d;
      int          exp;
      for (int i = 0; i < 16; i++) begin
         m      = 2'($urandom_range(0, 3));
         d      = 16'($urandom);
         a_req  = m;
         a_data = d;
         @(negedge clk);
         if (m == 2'b00) begin
            checks++; if (a_send !== 1'b0 || a_busy !== 1'b0) $display("FAIL rand_noreq iter %0d got send=%0b busy=%0b exp 0", i, a_send, a_busy); else passed++;
         end else begin
            exp = rr_pick({2'b00, m}, a_last, 2);
            checks++; if (a_send !== 1'b1 || a_gid !== 1'(exp)) $display("FAIL rand_grant iter %0d got send=%0b gid=%0d exp 1,%0d", i, a_send, a_gid, exp); else passed++;
            checks++; if (a_txd !== d[8*exp +: 8] || a_ack !== 2'(1 << exp)) $display("FAIL rand_data iter %0d got %0h/%0b exp %0h/%0b", i, a_txd, a_ack, d[8*exp +: 8], 2'(1 << exp)); else passed++;
            a_last = exp;
            a_req  = 2'b00;
            a_frame($urandom_range(0, 3), $urandom_range(2, 6));
            @(negedge clk);
            checks++; if (a_busy !== 1'b0) $display("FAIL rand_idle iter %0d got %0b exp 0", i, a_busy); else passed++;
         end
      end
   endtask

   task automatic test_late();
      a_req  = 2'b01;
      a_data = {8'h5C, 8'h3B};
      @(negedge clk);
      checks++; if (a_send !== 1'b1 || a_ack !== 2'b01) $display("FAIL late_first got send=%0b ack=%0b exp 1,01", a_send, a_ack); else passed++;
      a_last = 0;
      a_req  = 2'b00;
      a_st   = 3'd3;
      repeat (2) @(negedge clk);
      a_req = 2'b10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (a_ack !== 2'b00 || a_send !== 1'b0) $display("FAIL late_ignored cyc %0d got ack=%0b send=%0b exp 0", i, a_ack, a_send); else passed++;
      end
      a_st = 3'd0;
      @(negedge clk);
      checks++; if (a_busy !== 1'b0 || a_send !== 1'b0) $display("FAIL late_idle got busy=%0b send=%0b exp 0,0", a_busy, a_send); else passed++;
      @(negedge clk);
      checks++; if (a_send !== 1'b1 || a_ack !== 2'b10 || a_txd !== 8'h5C) $display("FAIL late_grant got send=%0b ack=%0b txd=%0h exp 1,10,5c", a_send, a_ack, a_txd); else passed++;
      a_last = 1;
      a_req  = 2'b00;
      a_frame(0, 3);
      @(negedge clk);
      checks++; if (a_busy !== 1'b0) $display("FAIL late_end got %0b exp 0", a_busy); else passed++;
   endtask

   task automatic test_gap();
      bit         ok;
      int         exp;
      int         cnt;
      logic [1:0] prev;
      b_req  = 3'b111;
      b_data = 24'($urandom);
      prev   = 2'd3;
      ok     = 1'b0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (b_send) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (!ok) $display("FAIL gap_first got none exp tx_send"); else passed++;
      for (int i = 0; i < 4; i++) begin
         exp = rr_pick({1'b0, b_req}, b_last, 3);
         checks++; if (b_gid !== 2'(exp) || b_gid === prev) $display("FAIL gap_gid iter %0d got %0d exp %0d prev %0d", i, b_gid, exp, prev); else passed++;
         checks++; if (b_txd !== b_data[8*exp +: 8] || b_ack !== 3'(1 << exp)) $display("FAIL gap_data iter %0d got %0h/%0b exp %0h/%0b", i, b_txd, b_ack, b_data[8*exp +: 8], 3'(1 << exp)); else passed++;
         prev   = b_gid;
         b_last = exp;
         b_st   = 3'd3;
         repeat ($urandom_range(2, 5)) @(negedge clk);
         b_st = 3'd0;
         if (i == 3) b_req = 3'b000;
         cnt = 0;
         ok  = 1'b0;
         for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (b_send || (i == 3 && !b_busy)) begin
               ok = 1'b1;
               break;
            end
            if (b_busy) cnt++;
         end
         checks++; if (!ok) $display("FAIL gap_next_timeout iter %0d got none exp event", i); else passed++;
         checks++; if (cnt !== 5) $display("FAIL gap_len iter %0d got %0d exp 5", i, cnt); else passed++;
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int exp;
      a_req  = 2'b11;
      a_data = {8'h9E, 8'h47};
      a_wait_send(ok);
      exp = rr_pick({2'b00, a_req}, a_last, 2);
      checks++; if (!ok || a_gid !== 1'(exp)) $display("FAIL rmid_pre got ok=%0b gid=%0d exp 1,%0d", ok, a_gid, exp); else passed++;
      a_st = 3'd3;
      repeat (3) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      checks++; if (a_busy !== 1'b0 || a_send !== 1'b0 || a_ack !== 2'b00) $display("FAIL rmid_clear got busy=%0b send=%0b ack=%0b exp 0", a_busy, a_send, a_ack); else passed++;
      checks++; if (a_txd !== 8'h00 || a_gid !== 1'b0) $display("FAIL rmid_data got txd=%0h gid=%0d exp 0,0", a_txd, a_gid); else passed++;
      @(negedge clk);
      a_st   = 3'd0;
      a_last = 1;
      b_last = 2;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      checks++; if (a_send !== 1'b1 || a_gid !== 1'b0 || a_txd !== 8'h47) $display("FAIL rmid_after got send=%0b gid=%0d txd=%0h exp 1,0,47", a_send, a_gid, a_txd); else passed++;
      a_last = 0;
      a_req  = 2'b00;
      a_frame(0, 3);
      @(negedge clk);
      checks++; if (a_busy !== 1'b0) $display("FAIL rmid_end got %0b exp 0", a_busy); else passed++;
   endtask

`ifdef UART_ARB_TIMEOUT_EN
   task automatic test_watchdog();
      a_req  = 2'b01;
      a_data = {8'hC3, 8'h6D};
      @(negedge clk);
      checks++; if (a_send !== 1'b1) $display("FAIL wd_send got %0b exp 1", a_send); else passed++;
      a_last = 0;
      a_req  = 2'b00;
      repeat (8) @(negedge clk);
      checks++; if (a_terr !== 1'b0 || a_busy !== 1'b1) $display("FAIL wd_early got err=%0b busy=%0b exp 0,1", a_terr, a_busy); else passed++;
      @(negedge clk);
      checks++; if (a_terr !== 1'b1 || a_busy !== 1'b0) $display("FAIL wd_fire got err=%0b busy=%0b exp 1,0", a_terr, a_busy); else passed++;
      a_req = 2'b10;
      @(negedge clk);
      checks++; if (a_send !== 1'b1 || a_gid !== 1'b1 || a_txd !== 8'hC3) $display("FAIL wd_next got send=%0b gid=%0d txd=%0h exp 1,1,c3", a_send, a_gid, a_txd); else passed++;
      a_last = 1;
      a_req  = 2'b00;
      a_frame(0, 3);
      @(negedge clk);
      checks++; if (a_terr !== 1'b1 || a_busy !== 1'b0) $display("FAIL wd_sticky got err=%0b busy=%0b exp 1,0", a_terr, a_busy); else passed++;
   endtask
`endif

   initial begin
      n_rst  = 1'b0;
      a_req  = '0;
      a_data = '0;
      a_st   = 3'd0;
      b_req  = '0;
      b_data = '0;
      b_st   = 3'd0;
      test_reset();
      test_contention();
      test_single();
      test_random();
      test_late();
      test_gap();
      test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
      test_watchdog();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1);
   end

endmodule
